// File: rtl/audio_i2s_tx_if.sv
// Purpose : sample input and I2S pin bundle for audio_i2s_tx.
// Ports   : i_sample/i_sample_valid (sample strobe in), o_bclk/o_lrclk/o_sdata
//           (I2S pins), o_frame_stb/o_overrun (status pulses).
// slave = the serialiser; master = whoever feeds samples and watches the pins.
interface audio_i2s_tx_if;
  logic [8:0] i_sample;
  logic       i_sample_valid;
  logic       o_bclk;
  logic       o_lrclk;
  logic       o_sdata;
  logic       o_frame_stb;
  logic       o_overrun;

  modport slave (
    input  i_sample, i_sample_valid,
    output o_bclk, o_lrclk, o_sdata, o_frame_stb, o_overrun
  );

  modport master (
    output i_sample, i_sample_valid,
    input  o_bclk, o_lrclk, o_sdata, o_frame_stb, o_overrun
  );
endinterface

// File: rtl/audio_i2s_tx.sv
// Purpose : I2S mono transmitter; 9-bit unsigned sample -> 16-bit two's complement,
//           MSB-first with one-bit delay, same word in left and right slots.
// Latency : sample valid to MSB on o_sdata <= 64N + 2N cycles; all outputs registered.
// Backpr. : none; one sample is held, a newer sample overwrites it (o_overrun pulses).
// Ports   : i_clk, i_rst (sync, active-high), io_i2s (slave modport of audio_i2s_tx_if).
module audio_i2s_tx #(
  parameter int CLKS_PER_BCLK_HALF = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  audio_i2s_tx_if.slave io_i2s
);

  localparam int N = CLKS_PER_BCLK_HALF;
  localparam int DIV_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(N - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_bclk;
  logic [4:0]       r_b;
  logic             r_lrclk;
  logic             r_sdata;
  logic             r_frame_stb;
  logic             r_overrun;
  logic [15:0]      r_word;
  logic [8:0]       r_held;
  logic             r_pending;

  logic             w_half_end;
  logic             w_fall;
  logic             w_latch;
  logic [4:0]       w_b_next;
  logic [3:0]       w_k;
  logic [3:0]       w_bit_idx;
  logic             w_bit;
  logic [15:0]      w_conv;

  assign w_half_end = (r_div == DIV_LAST);
  // BCLK is about to go 1->0: this is the only edge where data/word-select move.
  assign w_fall     = w_half_end && r_bclk;
  assign w_latch    = w_fall && (r_b == 5'd31);
  assign w_b_next   = r_b + 5'd1;
  assign w_k        = w_b_next[3:0];

  // 16-k (mod 16) selects word[15..1] for k=1..15 and wraps to word[0] for
  // k=0, which is exactly the delayed LSB of the slot just finished.
  assign w_bit_idx  = 4'd0 - w_k;
  assign w_bit      = r_word[w_bit_idx];

  // held - 256 is the offset-binary to two's complement flip of the top bit;
  // the result fits 9 signed bits, then scaled by 128 into the 16-bit word.
  assign w_conv     = {~r_held[8], r_held[7:0], 7'd0};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div       <= '0;
      r_bclk      <= 1'b0;
      r_b         <= 5'd0;
      r_lrclk     <= 1'b0;
      r_sdata     <= 1'b0;
      r_frame_stb <= 1'b0;
      r_overrun   <= 1'b0;
      r_word      <= 16'h0000;
      r_held      <= 9'd256;
      r_pending   <= 1'b0;
    end else begin
      // Bit clock divider.
      if (w_half_end) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div  <= r_div + DIV_W'(1);
      end

      // Slot position, word select and serial data all advance on the fall.
      if (w_fall) begin
        r_b     <= w_b_next;
        r_lrclk <= w_b_next[4];
        r_sdata <= w_bit;
        // Word swap happens after w_bit was taken from the old word.
        if (w_latch) begin
          r_word <= w_conv;
        end
      end

      r_frame_stb <= w_latch;
      // A sample arriving on the latch cycle is not an overrun: the old one
      // is consumed by the latch at the same edge.
      r_overrun   <= io_i2s.i_sample_valid && r_pending && !w_latch;

      if (io_i2s.i_sample_valid) begin
        r_held    <= io_i2s.i_sample;
        r_pending <= 1'b1;
      end else if (w_latch) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign io_i2s.o_bclk      = r_bclk;
  assign io_i2s.o_lrclk     = r_lrclk;
  assign io_i2s.o_sdata     = r_sdata;
  assign io_i2s.o_frame_stb = r_frame_stb;
  assign io_i2s.o_overrun   = r_overrun;

endmodule

// File: tb/tb_audio_i2s_tx.sv
module tb_audio_i2s_tx;

  localparam int N = 4;

  logic i_clk = 1'b0;
  logic i_rst;
  int   checks = 0;
  int   errors = 0;

  audio_i2s_tx_if bus ();

  audio_i2s_tx #(.CLKS_PER_BCLK_HALF(N)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .io_i2s (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int   cyc;
    logic bclk;
    logic lrclk;
    logic stb;
    logic ovr;
  } tvec_t;

  tvec_t tv[11];

  logic [15:0] cap_l, cap_r;
  int          cap_ovr, cap_stb_extra, cap_unstable;
  logic        cap_lr1, cap_lr16;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " bclk"},  32'(bus.o_bclk),      32'd0);
    chk({tag, " lrclk"}, 32'(bus.o_lrclk),     32'd0);
    chk({tag, " sdata"}, 32'(bus.o_sdata),     32'd0);
    chk({tag, " stb"},   32'(bus.o_frame_stb), 32'd0);
    chk({tag, " ovr"},   32'(bus.o_overrun),   32'd0);
  endtask

  // Steps from release (cycle 0) to cycle 256, checking the table entries.
  task automatic run_timing(input bit do_strobe, input string tag);
    int idx = 0;
    for (int c = 1; c <= 256; c++) begin
      if (do_strobe && c == 11) begin
        bus.i_sample       = 9'd511;
        bus.i_sample_valid = 1'b1;
      end
      tick();
      bus.i_sample_valid = 1'b0;
      if (idx < 11 && tv[idx].cyc == c) begin
        chk($sformatf("%s c%0d bclk", tag, c),  32'(bus.o_bclk),      32'(tv[idx].bclk));
        chk($sformatf("%s c%0d lrclk", tag, c), 32'(bus.o_lrclk),     32'(tv[idx].lrclk));
        chk($sformatf("%s c%0d stb", tag, c),   32'(bus.o_frame_stb), 32'(tv[idx].stb));
        chk($sformatf("%s c%0d ovr", tag, c),   32'(bus.o_overrun),   32'(tv[idx].ovr));
        idx++;
      end
    end
  endtask

  // Called positioned just after a frame latch; shifts in both slots and ends
  // positioned just after the next latch.
  task automatic capture(input int s1_j, input logic [8:0] s1_v,
                         input int s2_j, input logic [8:0] s2_v,
                         input bit end_stb, input logic [8:0] end_v);
    logic last_fall;
    cap_l = 'x; cap_r = 'x;
    cap_ovr = 0; cap_stb_extra = 0; cap_unstable = 0;
    cap_lr1 = 1'bx; cap_lr16 = 1'bx;
    last_fall = bus.o_sdata;
    for (int j = 1; j <= 32; j++) begin
      for (int t = 0; t < 2 * N; t++) begin
        if (t == 0 && j == s1_j) begin
          bus.i_sample = s1_v; bus.i_sample_valid = 1'b1;
        end
        if (t == 0 && j == s2_j) begin
          bus.i_sample = s2_v; bus.i_sample_valid = 1'b1;
        end
        if (end_stb && j == 32 && t == 2 * N - 1) begin
          bus.i_sample = end_v; bus.i_sample_valid = 1'b1;
        end
        tick();
        bus.i_sample_valid = 1'b0;
        if (bus.o_overrun === 1'b1) cap_ovr++;
        if (bus.o_frame_stb === 1'b1 && !(j == 32 && t == 2 * N - 1)) cap_stb_extra++;
        if (t == N - 1 && bus.o_sdata !== last_fall) cap_unstable++;
      end
      last_fall = bus.o_sdata;
      if (j < 16)       cap_l[16 - j] = bus.o_sdata;
      else if (j == 16) cap_l[0] = bus.o_sdata;
      else if (j < 32)  cap_r[32 - j] = bus.o_sdata;
      else              cap_r[0] = bus.o_sdata;
      if (j == 1)  cap_lr1 = bus.o_lrclk;
      if (j == 16) cap_lr16 = bus.o_lrclk;
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] exp_word, input int exp_ovr);
    chk({tag, " left"},     32'(cap_l),         32'(exp_word));
    chk({tag, " right"},    32'(cap_r),         32'(exp_word));
    chk({tag, " overrun"},  32'(cap_ovr),       32'(exp_ovr));
    chk({tag, " stray stb"}, 32'(cap_stb_extra), 32'd0);
    chk({tag, " rise chg"}, 32'(cap_unstable),  32'd0);
    chk({tag, " lr@1"},     32'(cap_lr1),       32'd0);
    chk({tag, " lr@16"},    32'(cap_lr16),      32'd1);
    chk({tag, " next stb"}, 32'(bus.o_frame_stb), 32'd1);
  endtask

  initial begin
    tv[0]  = '{1,   1'b0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{3,   1'b0, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{4,   1'b1, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{7,   1'b1, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{8,   1'b0, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{12,  1'b1, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{16,  1'b0, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{127, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{128, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[9]  = '{255, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[10] = '{256, 1'b0, 1'b0, 1'b1, 1'b0};

    bus.i_sample       = 9'd0;
    bus.i_sample_valid = 1'b0;
    i_rst              = 1'b1;
    repeat (3) tick();
    chk_outputs_zero("reset");
    i_rst = 1'b0;

    // Power-on timing, with 511 strobed during the first frame.
    run_timing(1'b1, "t0");
    chk("latch0 sdata", 32'(bus.o_sdata), 32'd0);

    // F1 = 511; strobe 0 for the next frame.
    capture(5, 9'd0, -1, 9'd0, 1'b0, 9'd0);
    check_frame("f511", 16'h7F80, 0);
    // F2 = 0; strobe 256.
    capture(3, 9'd256, -1, 9'd0, 1'b0, 9'd0);
    check_frame("f0", 16'h8000, 0);
    // F3 = 256; two strobes, newest (300) wins with one overrun.
    capture(2, 9'd100, 20, 9'd300, 1'b0, 9'd0);
    check_frame("f256", 16'h0000, 1);
    // F4 = 300; no strobe, so F5 repeats it.
    capture(-1, 9'd0, -1, 9'd0, 1'b0, 9'd0);
    check_frame("f300", 16'h1600, 0);
    // F5 repeat; 511 pending, then 0 arrives on the latch cycle itself.
    capture(4, 9'd511, -1, 9'd0, 1'b1, 9'd0);
    check_frame("frep", 16'h1600, 0);
    chk("coincident ovr", 32'(bus.o_overrun), 32'd0);
    // F6 uses the pre-latch held value; the coincident 0 lands in F7.
    capture(-1, 9'd0, -1, 9'd0, 1'b0, 9'd0);
    check_frame("fcoin", 16'h7F80, 0);
    capture(3, 9'd511, -1, 9'd0, 1'b0, 9'd0);
    check_frame("fafter", 16'h8000, 0);

    // Into F8 (0x7F80) up to b=20: bit 12 is on the pin.
    repeat (20 * 2 * N) tick();
    chk("b20 lrclk", 32'(bus.o_lrclk), 32'd1);
    chk("b20 sdata", 32'(bus.o_sdata), 32'd1);
    i_rst = 1'b1;
    tick();
    chk_outputs_zero("midreset");
    i_rst = 1'b0;

    // Restart must look like power-on, and the half-sent word is gone.
    run_timing(1'b0, "t1");
    capture(-1, 9'd0, -1, 9'd0, 1'b0, 9'd0);
    check_frame("fpost", 16'h0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
